// File: rtl/ctrl_resolve.sv
// Control-resolve stage: registers the control-execute write-back packet for one cycle,
// fans it out to the RF/bypass/AL/predictor, and arbitrates the oldest pending mispredict redirect.
module ctrl_resolve #(
  parameter int SIZE_PC      = 32,
  parameter int SIZE_DATA    = 32,
  parameter int SIZE_SEQ     = 16,
  parameter int SIZE_AL_LOG  = 7,
  parameter int SIZE_PHY_LOG = 7,
  parameter int SIZE_CTI_LOG = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,

  input  logic                    wbValid_i,
  input  logic [SIZE_SEQ-1:0]     wbSeqNo_i,
  input  logic [SIZE_PC-1:0]      wbPc_i,
  input  logic [SIZE_PC-1:0]      wbNextPC_i,
  input  logic                    wbDestValid_i,
  input  logic [SIZE_PHY_LOG-1:0] wbPhyDest_i,
  input  logic [SIZE_DATA-1:0]    wbDestData_i,
  input  logic [SIZE_AL_LOG-1:0]  wbAlID_i,
  input  logic [SIZE_CTI_LOG-1:0] wbCtiID_i,
  input  logic [1:0]              wbCtrlType_i,
  input  logic                    wbCtrlDir_i,
  input  logic                    wbMispredict_i,

  output logic                    rfWrEn_o,
  output logic [SIZE_PHY_LOG-1:0] rfWrAddr_o,
  output logic [SIZE_DATA-1:0]    rfWrData_o,
  output logic                    bypassValid_o,
  output logic [SIZE_PHY_LOG-1:0] bypassTag_o,
  output logic [SIZE_DATA-1:0]    bypassData_o,

  output logic                    alDone_o,
  output logic [SIZE_AL_LOG-1:0]  alDoneID_o,
  output logic                    alMispredict_o,

  output logic                    bpUpdValid_o,
  output logic [SIZE_PC-1:0]      bpUpdPc_o,
  output logic [SIZE_PC-1:0]      bpUpdTarget_o,
  output logic                    bpUpdDir_o,
  output logic [SIZE_CTI_LOG-1:0] bpUpdCtiID_o,
  output logic [1:0]              bpUpdType_o,

  output logic                    redirectValid_o,
  output logic [SIZE_PC-1:0]      redirectPC_o,
  output logic [SIZE_SEQ-1:0]     redirectSeqNo_o,
  input  logic                    redirectReady_i,

  output logic [15:0]             mispredCount_o
);

  typedef enum logic {IDLE, PEND} state_t;

  logic                    s1Valid_q;
  logic [SIZE_SEQ-1:0]     s1SeqNo_q;
  logic [SIZE_PC-1:0]      s1Pc_q;
  logic [SIZE_PC-1:0]      s1NextPc_q;
  logic                    s1DestValid_q;
  logic [SIZE_PHY_LOG-1:0] s1PhyDest_q;
  logic [SIZE_DATA-1:0]    s1DestData_q;
  logic [SIZE_AL_LOG-1:0]  s1AlId_q;
  logic [SIZE_CTI_LOG-1:0] s1CtiId_q;
  logic [1:0]              s1CtrlType_q;
  logic                    s1CtrlDir_q;
  logic                    s1Mispredict_q;

  state_t                  state_q, state_d;
  logic [SIZE_PC-1:0]      rPc_q, rPc_d;
  logic [SIZE_SEQ-1:0]     rSeq_q, rSeq_d;
  logic [15:0]             count_q, count_d;

  logic                    s1Mis;
  logic [SIZE_SEQ-1:0]     seqDiff;
  logic                    s1Older;

  // Payload fields are cleared on reset too so every output reads zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Valid_q      <= 1'b0;
      s1SeqNo_q      <= '0;
      s1Pc_q         <= '0;
      s1NextPc_q     <= '0;
      s1DestValid_q  <= 1'b0;
      s1PhyDest_q    <= '0;
      s1DestData_q   <= '0;
      s1AlId_q       <= '0;
      s1CtiId_q      <= '0;
      s1CtrlType_q   <= '0;
      s1CtrlDir_q    <= 1'b0;
      s1Mispredict_q <= 1'b0;
    end else begin
      s1Valid_q      <= wbValid_i & ~flush_i;
      s1SeqNo_q      <= wbSeqNo_i;
      s1Pc_q         <= wbPc_i;
      s1NextPc_q     <= wbNextPC_i;
      s1DestValid_q  <= wbDestValid_i;
      s1PhyDest_q    <= wbPhyDest_i;
      s1DestData_q   <= wbDestData_i;
      s1AlId_q       <= wbAlID_i;
      s1CtiId_q      <= wbCtiID_i;
      s1CtrlType_q   <= wbCtrlType_i;
      s1CtrlDir_q    <= wbCtrlDir_i;
      s1Mispredict_q <= wbMispredict_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rPc_q   <= '0;
      rSeq_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rPc_q   <= rPc_d;
      rSeq_q  <= rSeq_d;
      count_q <= count_d;
    end
  end

  assign s1Mis   = s1Valid_q & s1Mispredict_q;
  // Modular difference keeps the age test correct across sequence-number wrap.
  assign seqDiff = s1SeqNo_q - rSeq_q;
  assign s1Older = seqDiff[SIZE_SEQ-1];

  always_comb begin
    state_d = state_q;
    rPc_d   = rPc_q;
    rSeq_d  = rSeq_q;
    count_d = count_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (s1Mis) begin
            state_d = PEND;
            rPc_d   = s1NextPc_q;
            rSeq_d  = s1SeqNo_q;
          end
        end
        PEND: begin
          if (redirectReady_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
          end
          if (s1Mis && (redirectReady_i || s1Older)) begin
            rPc_d  = s1NextPc_q;
            rSeq_d = s1SeqNo_q;
          end else if (redirectReady_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rfWrEn_o        = s1Valid_q & s1DestValid_q;
  assign rfWrAddr_o      = s1PhyDest_q;
  assign rfWrData_o      = s1DestData_q;
  assign bypassValid_o   = s1Valid_q & s1DestValid_q;
  assign bypassTag_o     = s1PhyDest_q;
  assign bypassData_o    = s1DestData_q;

  assign alDone_o        = s1Valid_q;
  assign alDoneID_o      = s1AlId_q;
  assign alMispredict_o  = s1Valid_q & s1Mispredict_q;

  assign bpUpdValid_o    = s1Valid_q & (s1CtrlType_q != 2'd0);
  assign bpUpdPc_o       = s1Pc_q;
  assign bpUpdTarget_o   = s1NextPc_q;
  assign bpUpdDir_o      = s1CtrlDir_q;
  assign bpUpdCtiID_o    = s1CtiId_q;
  assign bpUpdType_o     = s1CtrlType_q;

  assign redirectValid_o = (state_q == PEND);
  assign redirectPC_o    = rPc_q;
  assign redirectSeqNo_o = rSeq_q;
  assign mispredCount_o  = count_q;

endmodule
